// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - Pacman move/collision classifier over a maze RAM (optional POWER_PELLET_EN)
module collision_detector #(
    parameter int MAZE_W = 28,
    parameter int MAZE_H = 31
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       move_req,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    input  logic [4:0] ghost_x,
    input  logic [4:0] ghost_y,
    output logic [9:0] tile_addr,
    input  logic [1:0] tile_rdata,
    output logic       tile_we,
    output logic [1:0] tile_wdata,
    output logic       busy,
    output logic       done,
    output logic       move_ok,
    output logic [3:0] collision_type
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CLASSIFY,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] CT_NONE  = 4'b0000;
    localparam logic [3:0] CT_WALL  = 4'b0001;
    localparam logic [3:0] CT_PILL  = 4'b0010;
    localparam logic [3:0] CT_POWER = 4'b0100;
    localparam logic [3:0] CT_GHOST = 4'b1000;

    state_t     state_q, state_d;
    logic [4:0] tx_q, tx_d;
    logic [4:0] ty_q, ty_d;
    logic [4:0] gx_q, gx_d;
    logic [4:0] gy_q, gy_d;
    logic [3:0] class_q, class_d;
    logic       ok_q, ok_d;
    logic       in_bounds;
    logic       ghost_hit;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            ty_q    <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            class_q <= CT_NONE;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            class_q <= class_d;
            ok_q    <= ok_d;
        end
    end

    assign in_bounds = (32'(tx_q) < MAZE_W) && (32'(ty_q) < MAZE_H);
    assign ghost_hit = (tx_q == gx_q) && (ty_q == gy_q);

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        class_d = class_q;
        ok_d    = ok_q;
        case (state_q)
            S_IDLE: begin
                if (move_req) begin
                    tx_d    = target_x;
                    ty_d    = target_y;
                    gx_d    = ghost_x;
                    gy_d    = ghost_y;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CLASSIFY;
            S_CLASSIFY: begin
                // Ghost wins over everything, so a ghost sitting on a pill leaves the pill intact.
                if (ghost_hit) begin
                    class_d = CT_GHOST;
                end else if (!in_bounds || tile_rdata == 2'b01) begin
                    class_d = CT_WALL;
                end else if (tile_rdata == 2'b11) begin
`ifdef POWER_PELLET_EN
                    class_d = CT_POWER;
`else
                    class_d = CT_PILL;
`endif
                end else if (tile_rdata == 2'b10) begin
                    class_d = CT_PILL;
                end else begin
                    class_d = CT_NONE;
                end
                ok_d    = (class_d != CT_WALL);
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign tile_addr      = {ty_q, tx_q};
    assign tile_wdata     = 2'b00;
    assign tile_we        = (state_q == S_WRITE) && ((class_q == CT_PILL) || (class_q == CT_POWER));
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign move_ok        = (state_q == S_DONE) ? ok_q : 1'b0;
    assign collision_type = (state_q == S_DONE) ? class_q : CT_NONE;

endmodule
